// File: rtl/otter_branch_predictor_pkg.sv
// otter_branch_predictor_pkg: shared sizing helpers and update classification for the branch predictor.
package otter_branch_predictor_pkg;

    typedef enum logic [1:0] {UPD_NONE, UPD_BR_NT, UPD_BR_T, UPD_JUMP} upd_kind_t;

    function automatic int idx_bits(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_bits(input int xlen, input int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/otter_branch_predictor_if.sv
// otter_branch_predictor_if: fetch lookup, resolve-stage training and status signals of the predictor.
interface otter_branch_predictor_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] LK_PC;
    logic            PRED_HIT;
    logic            PRED_TAKEN;
    logic [XLEN-1:0] PRED_TARGET;
    logic            UPD_VALID;
    logic [XLEN-1:0] UPD_PC;
    logic            UPD_IS_JUMP;
    logic            UPD_TAKEN;
    logic [XLEN-1:0] UPD_TARGET;
    logic            UPD_MISPRED;
    logic            INV_ALL;
    logic [31:0]     MISPRED_CNT;
    modport master (
        output LK_PC, UPD_VALID, UPD_PC, UPD_IS_JUMP, UPD_TAKEN, UPD_TARGET, UPD_MISPRED, INV_ALL,
        input  PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPRED_CNT
    );
    modport slave (
        input  LK_PC, UPD_VALID, UPD_PC, UPD_IS_JUMP, UPD_TAKEN, UPD_TARGET, UPD_MISPRED, INV_ALL,
        output PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPRED_CNT
    );
endinterface

// File: rtl/otter_branch_predictor_sat_counter.sv
// otter_sat_counter: W-bit up/down counter saturating at 0 and all-ones, updated on the falling edge.
module otter_sat_counter #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] i_rst_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(negedge CLK)
        r_q <= RST ? i_rst_val :
               (i_inc && r_q != '1) ? r_q + W'(1) :
               (i_dec && r_q != '0) ? r_q - W'(1) : r_q;

    assign o_q = r_q;
endmodule

// File: rtl/otter_branch_predictor.sv
// otter_branch_predictor: direct-mapped BTB plus PHT of saturating counters, bimodal or gshare indexed.
module otter_branch_predictor
    import otter_branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input logic CLK,
    input logic RST,
    otter_branch_predictor_if.slave bp
);
    localparam int IDX = idx_bits(ENTRIES);
    localparam int TW  = tag_bits(XLEN, ENTRIES);
    localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef struct packed {
        logic            valid;
        logic            jump;
        logic [TW-1:0]   tag;
        logic [XLEN-1:0] target;
    } bpred_entry_t;

    bpred_entry_t          r_btb [ENTRIES];
    logic [GW-1:0]         r_ghr;
    logic [31:0]           r_mispred_cnt;
    logic [CTR_BITS-1:0]   w_pht [ENTRIES];
    logic [ENTRIES-1:0]    w_pht_sel;
    logic [IDX-1:0]        w_ghr_ext;
    logic [IDX-1:0]        w_lk_bi;
    logic [IDX-1:0]        w_lk_pi;
    logic [IDX-1:0]        w_upd_bi;
    logic [IDX-1:0]        w_upd_pi;
    logic [TW-1:0]         w_lk_tag;
    logic [TW-1:0]         w_upd_tag;
    upd_kind_t             w_kind;
    logic                  w_br;
    logic                  w_btb_wr;
    bpred_entry_t          w_lk_e;
    logic                  w_hit;
    logic                  w_unused_bits;

    assign w_ghr_ext = (GHR_BITS == 0) ? '0 : IDX'(r_ghr);
    assign w_lk_bi   = bp.LK_PC[IDX+1:2];
    assign w_lk_tag  = bp.LK_PC[XLEN-1:IDX+2];
    assign w_lk_pi   = w_lk_bi ^ w_ghr_ext;
    assign w_upd_bi  = bp.UPD_PC[IDX+1:2];
    assign w_upd_tag = bp.UPD_PC[XLEN-1:IDX+2];
    assign w_upd_pi  = w_upd_bi ^ w_ghr_ext;
    assign w_unused_bits = ^{bp.LK_PC[1:0], bp.UPD_PC[1:0]};

    always_comb begin
        w_kind   = !bp.UPD_VALID ? UPD_NONE : bp.UPD_IS_JUMP ? UPD_JUMP : bp.UPD_TAKEN ? UPD_BR_T : UPD_BR_NT;
        w_br     = (w_kind == UPD_BR_T) || (w_kind == UPD_BR_NT);
        w_btb_wr = (w_kind == UPD_BR_T) || (w_kind == UPD_JUMP);
        w_pht_sel = w_br ? (ENTRIES'(1) << w_upd_pi) : '0;
    end

    // PHT counters reset together with RST; jumps never reach them since w_pht_sel is zero for jumps
    for (genvar k = 0; k < ENTRIES; k++) begin : g_pht
        otter_sat_counter #(.W(CTR_BITS)) u_ctr (
            .CLK      (CLK),
            .RST      (RST),
            .i_rst_val(CTR_RST),
            .i_inc    (w_pht_sel[k] && bp.UPD_TAKEN),
            .i_dec    (w_pht_sel[k] && !bp.UPD_TAKEN),
            .o_q      (w_pht[k])
        );
    end

    always_ff @(negedge CLK)
        if (RST || bp.INV_ALL)
            for (int i = 0; i < ENTRIES; i++) r_btb[i].valid <= 1'b0;
        else if (w_btb_wr)
            r_btb[w_upd_bi] <= '{valid: 1'b1, jump: bp.UPD_IS_JUMP, tag: w_upd_tag, target: bp.UPD_TARGET};

    always_ff @(negedge CLK)
        if (RST) begin
            r_ghr         <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_br && GHR_BITS > 0) r_ghr <= GW'({r_ghr, bp.UPD_TAKEN});
            if (bp.UPD_VALID && bp.UPD_MISPRED && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end

    assign w_lk_e         = r_btb[w_lk_bi];
    assign w_hit          = w_lk_e.valid && (w_lk_e.tag == w_lk_tag);
    assign bp.PRED_HIT    = w_hit;
    assign bp.PRED_TAKEN  = w_hit && (w_lk_e.jump || w_pht[w_lk_pi][CTR_BITS-1]);
    assign bp.PRED_TARGET = w_hit ? w_lk_e.target : '0;
    assign bp.MISPRED_CNT = r_mispred_cnt;
endmodule

// File: tb/tb_otter_branch_predictor.sv
// tb_otter_branch_predictor: directed checks of a bimodal and a gshare predictor instance.
module tb_otter_branch_predictor;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    otter_branch_predictor_if #(.XLEN(32)) bpi ();
    otter_branch_predictor_if #(.XLEN(32)) bpg ();

    otter_branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2), .GHR_BITS(0)) dut (
        .CLK(CLK), .RST(RST), .bp(bpi)
    );
    otter_branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2), .GHR_BITS(2)) dut_g (
        .CLK(CLK), .RST(RST), .bp(bpg)
    );

    task automatic look(input logic [31:0] pc);
        bpi.LK_PC = pc;
        #1;
    endtask

    // Presents one update for exactly one falling edge, returning just after the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn, input logic [31:0] tgt,
                       input logic mis, input logic inv);
        @(posedge CLK); #1;
        bpi.UPD_VALID = 1'b1; bpi.UPD_PC = pc; bpi.UPD_IS_JUMP = jmp; bpi.UPD_TAKEN = tkn;
        bpi.UPD_TARGET = tgt; bpi.UPD_MISPRED = mis; bpi.INV_ALL = inv;
        @(posedge CLK); #1;
        bpi.UPD_VALID = 1'b0; bpi.UPD_MISPRED = 1'b0; bpi.INV_ALL = 1'b0;
    endtask

    task automatic test_reset;
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bpi.PRED_TAKEN); end
        checks++; if (bpi.PRED_TARGET !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", bpi.PRED_TARGET); end
        checks++; if (bpi.MISPRED_CNT !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bpi.MISPRED_CNT); end
        checks++; if (dut_g.r_ghr !== 2'b00) begin errors++; $display("FAIL reset_ghr got %b exp 00", dut_g.r_ghr); end
    endtask

    task automatic test_bimodal;
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b1) begin errors++; $display("FAIL bim_hit got %b exp 1", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL bim_taken got %b exp 1", bpi.PRED_TAKEN); end
        checks++; if (bpi.PRED_TARGET !== 32'h80) begin errors++; $display("FAIL bim_target got %h exp 80", bpi.PRED_TARGET); end
        for (int i = 0; i < 2; i++) upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b1) begin errors++; $display("FAIL bim_nt_hit got %b exp 1", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL bim_nt_taken got %b exp 0", bpi.PRED_TAKEN); end
        for (int i = 0; i < 5; i++) upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL bim_sat_taken got %b exp 0", bpi.PRED_TAKEN); end
        // Counter is pinned at 00, so one taken update only reaches 01
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL bim_sat_floor got %b exp 0", bpi.PRED_TAKEN); end
    endtask

    task automatic test_jump_alias;
        upd(32'h200, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0);
        look(32'h200);
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL jmp_taken got %b exp 1", bpi.PRED_TAKEN); end
        checks++; if (bpi.PRED_TARGET !== 32'h400) begin errors++; $display("FAIL jmp_target got %h exp 400", bpi.PRED_TARGET); end
        look(32'h240);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL alias_miss got %b exp 0", bpi.PRED_HIT); end
        upd(32'h240, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        look(32'h240);
        checks++; if (bpi.PRED_HIT !== 1'b1) begin errors++; $display("FAIL alias_hit got %b exp 1", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL alias_taken got %b exp 1", bpi.PRED_TAKEN); end
        checks++; if (bpi.PRED_TARGET !== 32'h300) begin errors++; $display("FAIL alias_target got %h exp 300", bpi.PRED_TARGET); end
        look(32'h200);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL evict_miss got %b exp 0", bpi.PRED_HIT); end
    endtask

    task automatic test_same_cycle;
        @(posedge CLK); #1;
        bpi.LK_PC = 32'h100;
        bpi.UPD_VALID = 1'b1; bpi.UPD_PC = 32'h100; bpi.UPD_IS_JUMP = 1'b0; bpi.UPD_TAKEN = 1'b1;
        bpi.UPD_TARGET = 32'h90; bpi.UPD_MISPRED = 1'b0;
        #1;
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL same_old_hit got %b exp 0", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TARGET !== 32'h0) begin errors++; $display("FAIL same_old_target got %h exp 0", bpi.PRED_TARGET); end
        @(posedge CLK); #1;
        bpi.UPD_VALID = 1'b0;
        checks++; if (bpi.PRED_HIT !== 1'b1) begin errors++; $display("FAIL same_new_hit got %b exp 1", bpi.PRED_HIT); end
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL same_new_taken got %b exp 1", bpi.PRED_TAKEN); end
        checks++; if (bpi.PRED_TARGET !== 32'h90) begin errors++; $display("FAIL same_new_target got %h exp 90", bpi.PRED_TARGET); end
    endtask

    task automatic test_gshare;
        logic [1:0] m_pht [4];
        logic [1:0] m_ghr;
        logic       m_hit;
        logic       tkn;
        logic       exp_t;
        for (int i = 0; i < 4; i++) m_pht[i] = 2'b01;
        m_ghr = 2'b00;
        m_hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tkn = (i % 2 == 0);
            exp_t = m_hit && m_pht[m_ghr][1];
            @(posedge CLK); #1;
            bpg.LK_PC = 32'h100;
            #1;
            checks++; if (bpg.PRED_TAKEN !== exp_t) begin errors++; $display("FAIL gsh_pred[%0d] got %b exp %b", i, bpg.PRED_TAKEN, exp_t); end
            if (i >= 3) begin
                checks++; if (bpg.PRED_TAKEN !== tkn) begin errors++; $display("FAIL gsh_track[%0d] got %b exp %b", i, bpg.PRED_TAKEN, tkn); end
            end
            bpg.UPD_VALID = 1'b1; bpg.UPD_PC = 32'h100; bpg.UPD_IS_JUMP = 1'b0; bpg.UPD_TAKEN = tkn;
            bpg.UPD_TARGET = 32'h80;
            @(posedge CLK); #1;
            bpg.UPD_VALID = 1'b0;
            if (tkn && m_pht[m_ghr] != 2'b11) m_pht[m_ghr] = m_pht[m_ghr] + 2'd1;
            if (!tkn && m_pht[m_ghr] != 2'b00) m_pht[m_ghr] = m_pht[m_ghr] - 2'd1;
            if (tkn) m_hit = 1'b1;
            m_ghr = {m_ghr[0], tkn};
            checks++; if (dut_g.r_ghr !== m_ghr) begin errors++; $display("FAIL gsh_ghr[%0d] got %b exp %b", i, dut_g.r_ghr, m_ghr); end
        end
    endtask

    task automatic test_inv_all;
        upd(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL inv_miss100 got %b exp 0", bpi.PRED_HIT); end
        look(32'h240);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL inv_miss240 got %b exp 0", bpi.PRED_HIT); end
        upd(32'h100, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL inv_retrain got %b exp 1", bpi.PRED_TAKEN); end
        checks++; if (bpi.MISPRED_CNT !== 32'd1) begin errors++; $display("FAIL inv_cnt got %0d exp 1", bpi.MISPRED_CNT); end
        upd(32'h100, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b1);
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL inv_wins got %b exp 0", bpi.PRED_HIT); end
    endtask

    task automatic test_reset_mid;
        @(posedge CLK); #1;
        RST = 1'b1;
        bpi.UPD_VALID = 1'b1; bpi.UPD_PC = 32'h300; bpi.UPD_IS_JUMP = 1'b1; bpi.UPD_TAKEN = 1'b1;
        bpi.UPD_TARGET = 32'h500; bpi.UPD_MISPRED = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; bpi.UPD_VALID = 1'b0; bpi.UPD_MISPRED = 1'b0;
        look(32'h300);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", bpi.PRED_HIT); end
        checks++; if (bpi.MISPRED_CNT !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bpi.MISPRED_CNT); end
        look(32'h100);
        checks++; if (bpi.PRED_HIT !== 1'b0) begin errors++; $display("FAIL rst_miss100 got %b exp 0", bpi.PRED_HIT); end
        // From the 01 reset value: taken -> 10 (taken), not-taken -> 01 (not taken)
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_TAKEN !== 1'b1) begin errors++; $display("FAIL rst_pht_t got %b exp 1", bpi.PRED_TAKEN); end
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (bpi.PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL rst_pht_nt got %b exp 0", bpi.PRED_TAKEN); end
    endtask

    task automatic test_mispred_cnt;
        for (int i = 0; i < 70; i++) upd(32'h1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge CLK); #1;
        bpi.UPD_MISPRED = 1'b1;
        @(posedge CLK); #1;
        bpi.UPD_MISPRED = 1'b0;
        checks++; if (bpi.MISPRED_CNT !== 32'd70) begin errors++; $display("FAIL mis_cnt got %0d exp 70", bpi.MISPRED_CNT); end
    endtask

    initial begin
        bpi.LK_PC = '0; bpi.UPD_VALID = 0; bpi.UPD_PC = '0; bpi.UPD_IS_JUMP = 0; bpi.UPD_TAKEN = 0;
        bpi.UPD_TARGET = '0; bpi.UPD_MISPRED = 0; bpi.INV_ALL = 0;
        bpg.LK_PC = '0; bpg.UPD_VALID = 0; bpg.UPD_PC = '0; bpg.UPD_IS_JUMP = 0; bpg.UPD_TAKEN = 0;
        bpg.UPD_TARGET = '0; bpg.UPD_MISPRED = 0; bpg.INV_ALL = 0;
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        test_reset();
        test_bimodal();
        test_jump_alias();
        test_same_cycle();
        test_gshare();
        test_inv_all();
        test_reset_mid();
        test_mispred_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
